demux_scan_seq: RTL and testbench
=================================

Name: demux_scan_seq

Overview:
- Upstream sequencer for the 1-to-8 demultiplexer.
- Accepts an 8-bit frame over a valid/ready handshake, then scans channels 0..7 in order.
- For each channel it drives the demux select and the frame bit for that channel.
- It holds each channel for a programmable number of cycles, then reports completion.

Parameters:
- N_CH, 8, number of demux channels; must be a power of 2.
- SEL_W, 3, select width; equals log2(N_CH).
- HOLD_CYCLES, 2, cycles each channel is held; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- frame_valid  input  1  upstream frame offered.
- frame_data  input  N_CH  frame; bit k goes to channel k.
- frame_ready  output  1  sequencer can accept a frame this cycle.
- demux_i  output  1  data bit to the demux input.
- demux_s  output  SEL_W  channel select to the demux.
- demux_en  output  1  high while demux_i/demux_s carry a valid channel value.
- busy  output  1  a scan is in progress.
- done  output  1  one-cycle pulse after channel N_CH-1 finishes its hold.

Behaviour:
- Reset (async, rst_n=0), all outputs registered and cleared immediately:
  - state=IDLE, demux_i=0, demux_s=0, demux_en=0, busy=0, done=0.
  - frame_ready=0 while reset is asserted; it goes to 1 on the first clock edge after release.
- States: IDLE, DRIVE, DONE (plus GAP when the optional feature is compiled in).
- frame_ready=1 in IDLE and DONE, 0 otherwise.
- Accept: frame_valid && frame_ready at edge t.
  - Latch frame_data into frame_q.
  - Go to DRIVE with demux_s=0, hold_cnt=0.
  - frame_data is ignored from then until the next accept.
- DRIVE:
  - demux_en=1, busy=1, demux_i=frame_q[demux_s].
  - hold_cnt increments every cycle.
  - When hold_cnt==HOLD_CYCLES-1: clear hold_cnt.
    - If demux_s==N_CH-1, go to DONE.
    - Otherwise increment demux_s.
- Timing for an accept at edge t:
  - Channel k is visible from edge t+1+k*HOLD_CYCLES for exactly HOLD_CYCLES cycles.
  - Total scan is N_CH*HOLD_CYCLES cycles.
  - done is high in the cycle after the last hold.
- DONE:
  - done=1 for exactly one cycle; demux_en=0, busy=0, demux_s holds N_CH-1, demux_i=0.
  - If frame_valid is high in DONE, the new frame is accepted and the next cycle is DRIVE with demux_s=0. Back-to-back scans have one dead cycle.
  - Otherwise the next state is IDLE.
- IDLE: demux_en=0, demux_i=0, demux_s=0.
- frame_valid during DRIVE: not accepted (frame_ready=0). The upstream must hold it until frame_ready.
- HOLD_CYCLES=1: channel changes every cycle and the scan takes 8 cycles.
- demux_s never exceeds N_CH-1; no wrap-around inside a scan.
- Reset mid-scan: scan is abandoned, no done pulse, frame_q is cleared.

Optional Feature:
- Macro: DEMUX_SCAN_GAP_EN.
- Defined:
  - One GAP cycle is inserted after each channel hold, except after the last channel.
  - In GAP, demux_en=0 and demux_i=0; demux_s already shows the next channel.
  - Scan length becomes N_CH*HOLD_CYCLES + N_CH-1 cycles.
  - busy stays 1 through GAP.
- Undefined: no GAP state; timing exactly as in Behaviour.

Decomposition:
- Package demux_pkg holds:
  - Constants DEMUX_N_CH=8 and DEMUX_SEL_W=3.
  - State enum scan_state_t {IDLE, DRIVE, GAP, DONE}, sized 2 bits.
- One sub-module: demux_hold_timer.
  - Counts 0..HOLD_CYCLES-1 with clear and enable inputs.
  - Outputs a terminal-count pulse.
- The FSM and select counter stay in demux_scan_seq.
- A top-level bench instantiates demux_scan_seq feeding mux_1to8 via demux_i/demux_s.

Test Plan:
- Reset release, frame_valid=0 for 10 cycles -> frame_ready=1, demux_en=0, busy=0, done=0 throughout.
- frame_data=8'b1010_0101, HOLD_CYCLES=2, accept at edge t -> demux_s=0..7 for 2 cycles each; demux_i sequence 1,0,1,0,0,1,0,1; done high at cycle t+17; downstream y shows the bit on channel s only.
- Second frame 8'hFF held valid during the scan -> not accepted until DONE; accepted in the DONE cycle; next DRIVE starts with demux_s=0 and no IDLE cycle in between.
- HOLD_CYCLES=1, frame 8'h01 -> demux_i=1 only in the first DRIVE cycle; scan is exactly 8 cycles; done is one cycle wide.
- rst_n pulsed low while demux_s=3 -> outputs zero immediately (asynchronously), no done pulse; after release, frame_ready=1 and a fresh scan of 8'h80 completes normally.
- DEMUX_SCAN_GAP_EN defined, HOLD_CYCLES=2, frame 8'hAA -> demux_en pattern 1,1,0 repeated with no gap after channel 7; done at cycle t+24.

Source files
------------

// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants and types for the demux scan sequencer.
//   DEMUX_N_CH          : number of demux channels (power of 2)
//   DEMUX_SEL_W         : select width, log2(DEMUX_N_CH)
//   DEMUX_HOLD_DEFAULT  : default number of cycles each channel is held
//   scan_state_t        : sequencer state encoding (GAP is only reached when
//                         the design is built with DEMUX_SCAN_GAP_EN)
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int DEMUX_N_CH         = 8;
  localparam int DEMUX_SEL_W        = 3;
  localparam int DEMUX_HOLD_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

endpackage : demux_pkg

// File: rtl/demux_hold_timer.sv
// -----------------------------------------------------------------------------
// demux_hold_timer
// Counts 0..HOLD_CYCLES-1 while enabled and wraps to 0 on terminal count.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : advance the count this cycle
//   tc         : terminal-count pulse, high in the enabled cycle where the
//                count equals HOLD_CYCLES-1
// -----------------------------------------------------------------------------
module demux_hold_timer #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : demux_hold_timer

// File: rtl/demux_scan_seq.sv
// -----------------------------------------------------------------------------
// demux_scan_seq
// Upstream sequencer for a 1-to-N_CH demultiplexer. Accepts a frame over a
// valid/ready handshake, then presents channels 0..N_CH-1 in order, holding
// each for HOLD_CYCLES cycles, and pulses done once the last hold ends.
//
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   frame_valid  : upstream frame offered
//   frame_data   : frame, bit k goes to channel k
//   frame_ready  : frame can be accepted this cycle (IDLE or DONE)
//   demux_i      : data bit for the demux input
//   demux_s      : demux channel select
//   demux_en     : demux_i/demux_s carry a valid channel value
//   busy         : scan in progress
//   done         : one-cycle pulse after the last channel's hold
//
// Build option: DEMUX_SCAN_GAP_EN inserts one GAP cycle (demux_en=0, select
// already on the next channel) after every channel hold except the last.
//
// All outputs are registered; their next values are decoded from the next
// state, so an accept on one edge shows channel 0 right after that edge.
// -----------------------------------------------------------------------------
module demux_scan_seq
  import demux_pkg::*;
#(
  parameter int N_CH        = DEMUX_N_CH,
  parameter int SEL_W       = DEMUX_SEL_W,
  parameter int HOLD_CYCLES = DEMUX_HOLD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_valid,
  input  logic [N_CH-1:0]  frame_data,
  output logic             frame_ready,
  output logic             demux_i,
  output logic [SEL_W-1:0] demux_s,
  output logic             demux_en,
  output logic             busy,
  output logic             done
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  scan_state_t      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_CH-1:0]  frame_q, frame_d;
  logic             frame_ready_q, frame_ready_d;
  logic             demux_i_q, demux_i_d;
  logic             demux_en_q, demux_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic accept;
  logic timer_clr;
  logic timer_en;
  logic hold_tc;

  // frame_ready_q mirrors "state is IDLE or DONE" except in the first cycle
  // after reset release, where it is still 0 and so blocks an accept.
  assign accept = frame_valid && frame_ready_q;

  demux_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .tc    (hold_tc)
  );

  // Next-state, select counter and registered-output decode.
  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    frame_d   = frame_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          frame_d   = frame_data;
          sel_d     = '0;
          timer_clr = 1'b1;
          state_d   = DRIVE;
        end else begin
          sel_d   = '0;
          state_d = IDLE;
        end
      end

      DRIVE: begin
        timer_en = 1'b1;
        if (hold_tc) begin
          if (sel_q == LAST_CH) begin
            // Select stays on the last channel through DONE.
            state_d = DONE;
          end else begin
            sel_d = sel_q + 1'b1;
`ifdef DEMUX_SCAN_GAP_EN
            state_d = GAP;
`endif
          end
        end
      end

`ifdef DEMUX_SCAN_GAP_EN
      GAP: begin
        // Timer already wrapped to 0 on the previous terminal count.
        state_d = DRIVE;
      end
`endif

      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase

    frame_ready_d = (state_d == IDLE) || (state_d == DONE);
    demux_en_d    = (state_d == DRIVE);
    demux_i_d     = (state_d == DRIVE) ? frame_d[sel_d] : 1'b0;
    done_d        = (state_d == DONE);
`ifdef DEMUX_SCAN_GAP_EN
    busy_d        = (state_d == DRIVE) || (state_d == GAP);
`else
    busy_d        = (state_d == DRIVE);
`endif
  end

  // NOTE: the frame register is reset along with the control state so an
  // abandoned scan leaves no stale data behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      frame_q       <= '0;
      frame_ready_q <= 1'b0;
      demux_i_q     <= 1'b0;
      demux_en_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      frame_q       <= frame_d;
      frame_ready_q <= frame_ready_d;
      demux_i_q     <= demux_i_d;
      demux_en_q    <= demux_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign frame_ready = frame_ready_q;
  assign demux_i     = demux_i_q;
  assign demux_s     = sel_q;
  assign demux_en    = demux_en_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule : demux_scan_seq

// File: tb/tb_demux_scan_seq.sv
// -----------------------------------------------------------------------------
// tb_demux_scan_seq
// Drives two sequencers (HOLD_CYCLES=2 and HOLD_CYCLES=1) and compares every
// output, every cycle, with a reference model that derives the expected
// channel view from the cycle offset since the accepting edge. A behavioural
// 1-to-8 demux on the DUT outputs checks that only channel s carries the bit.
// Build with DEMUX_SCAN_GAP_EN defined to check the GAP variant.
// -----------------------------------------------------------------------------
module tb_demux_scan_seq;

  localparam int N = 8;
`ifdef DEMUX_SCAN_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic       ready;
    logic       i;
    logic [2:0] s;
    logic       en;
    logic       busy;
    logic       done;
    logic [7:0] y;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fv    [2];
  logic [7:0] fd    [2];
  logic       rdy   [2];
  logic       di    [2];
  logic [2:0] ds    [2];
  logic       den   [2];
  logic       bsy   [2];
  logic       dne   [2];

  demux_scan_seq #(.N_CH(8), .SEL_W(3), .HOLD_CYCLES(2)) u_dut_h2 (
    .clk(clk), .rst_n(rst_n), .frame_valid(fv[0]), .frame_data(fd[0]),
    .frame_ready(rdy[0]), .demux_i(di[0]), .demux_s(ds[0]),
    .demux_en(den[0]), .busy(bsy[0]), .done(dne[0])
  );

  demux_scan_seq #(.N_CH(8), .SEL_W(3), .HOLD_CYCLES(1)) u_dut_h1 (
    .clk(clk), .rst_n(rst_n), .frame_valid(fv[1]), .frame_data(fd[1]),
    .frame_ready(rdy[1]), .demux_i(di[1]), .demux_s(ds[1]),
    .demux_en(den[1]), .busy(bsy[1]), .done(dne[1])
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: m_j = -1 idle, 0..L-1 offset inside the scan, L = done cycle.
  int         m_j    [2];
  logic [7:0] m_f    [2];
  bit         rdy_ok [2];
  bit         drv_v  [2];
  logic [7:0] drv_d  [2];
  bit         drop   [2];

  function automatic int hold_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int scan_len(input int d);
    return N * hold_of(d) + (GAP_EN ? N - 1 : 0);
  endfunction

  function automatic exp_t model_out(input int d);
    exp_t e;
    int   h, per, ch, pos;
    e   = '0;
    h   = hold_of(d);
    per = GAP_EN ? h + 1 : h;
    if (m_j[d] < 0) begin
      e.ready = rdy_ok[d];
    end else if (m_j[d] >= scan_len(d)) begin
      e.ready = 1'b1;
      e.done  = 1'b1;
      e.s     = 3'(N - 1);
    end else begin
      ch     = m_j[d] / per;
      pos    = m_j[d] % per;
      e.busy = 1'b1;
      if (pos < h) begin
        e.en = 1'b1;
        e.s  = 3'(ch);
        e.i  = m_f[d][ch];
        e.y  = 8'(e.i) << ch;
      end else begin
        e.s  = 3'(ch + 1);
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(input int d);
    exp_t       e;
    logic [7:0] y_obs;
    string      p;
    e     = model_out(d);
    y_obs = den[d] ? (8'(di[d]) << ds[d]) : 8'h00;
    p     = (d == 0) ? "h2" : "h1";
    check({p, ".frame_ready"}, 32'(rdy[d]), 32'(e.ready));
    check({p, ".demux_en"},    32'(den[d]), 32'(e.en));
    check({p, ".demux_s"},     32'(ds[d]),  32'(e.s));
    check({p, ".demux_i"},     32'(di[d]),  32'(e.i));
    check({p, ".busy"},        32'(bsy[d]), 32'(e.busy));
    check({p, ".done"},        32'(dne[d]), 32'(e.done));
    check({p, ".y"},           32'(y_obs),  32'(e.y));
  endtask

  // Entered and left at a falling edge: check, drive, advance the model.
  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        e = model_out(d);
        check_dut(d);
        fv[d] = drv_v[d];
        fd[d] = drv_v[d] ? drv_d[d] : 8'($urandom);
        if (drv_v[d] && e.ready) begin
          m_j[d] = 0;
          m_f[d] = drv_d[d];
          if (drop[d]) drv_v[d] = 1'b0;
        end else if (m_j[d] >= 0) begin
          m_j[d] = (m_j[d] >= scan_len(d)) ? -1 : m_j[d] + 1;
        end
        rdy_ok[d] = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic send(input int d, input logic [7:0] data, input bit drop_on_accept);
    drv_v[d] = 1'b1;
    drv_d[d] = data;
    drop[d]  = drop_on_accept;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_j[d]    = -1;
      m_f[d]    = '0;
      rdy_ok[d] = 1'b0;
      drv_v[d]  = 1'b0;
      fv[d]     = 1'b0;
    end
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    fd[0] = '0;
    fd[1] = '0;
    model_reset();
    #1;
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    rst_n = 1'b1;

    // Idle after reset release.
    step(10);

    // Main scan, H=2.
    send(0, 8'b1010_0101, 1'b1);
    step(22);

    // Second frame offered during a scan is held off until DONE, then
    // accepted with no idle cycle; H=1 runs a single-bit frame alongside.
    send(0, 8'h3C, 1'b1);
    send(1, 8'h01, 1'b1);
    step(3);
    send(0, 8'hFF, 1'b1);
    step(40);

    // Gap-pattern frame on H=2.
    send(0, 8'hAA, 1'b1);
    step(28);

    // Asynchronous reset while channel 3 is on the select.
    send(0, 8'($urandom) | 8'h08, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      exp_t e;
      e = model_out(0);
      if (e.en && e.s == 3'd3) found = 1'b1;
      else step(1);
    end
    check("h2.reach_s3", 32'(found), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    rst_n = 1'b1;
    step(2);
    send(0, 8'h80, 1'b1);
    step(24);

    // Randomised frames, channel choice, hold-or-drop valid and spacing.
    for (int r = 0; r < 10; r++) begin
      int d;
      d = int'($urandom_range(0, 1));
      send(d, 8'($urandom), bit'($urandom_range(0, 3) != 0));
      step(int'($urandom_range(3, 30)));
      drv_v[d] = 1'b0;
    end
    step(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_demux_scan_seq
